cook_sequencer: RTL and testbench

- Multi-stage cooking program controller for the microwave.
- Stores up to N_STAGES programmed stages; each stage holds power, minutes and seconds.
- Sequences the countdown timer through the stages in order: load, start, pause, stop, done.
- Modulates the magnetron enable by a duty cycle that follows each stage's power level.
- Sits between the edge-detected front-panel controls and the timer/display datapath.

---
 rtl/cook_pkg.sv | 41 ++++
 rtl/cook_stage_table.sv | 78 +++++++
 rtl/cook_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_cook_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cook_pkg.sv
// Shared definitions for the microwave cooking program sequencer.
// Contents: FSM state encoding, power codes, time limits, clamping and
// duty-cycle helpers used by cook_stage_table and cook_sequencer.
package cook_pkg;

  localparam int IDX_W = 2;

  localparam logic [6:0] MAX_MIN = 7'd99;
  localparam logic [6:0] MAX_SEC = 7'd59;

  localparam logic [1:0] PWR_LOW  = 2'd0;
  localparam logic [1:0] PWR_MED  = 2'd1;
  localparam logic [1:0] PWR_HIGH = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ARM   = 3'd2,
    RUN   = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_e;

  function automatic logic [6:0] clamp7(input logic [6:0] v, input logic [6:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // Magnetron on/off for a given power code and 4-slot duty phase.
  // Code 3 is not a defined level and is treated as full power.
  function automatic logic duty_on(input logic [1:0] pwr, input logic [1:0] slot);
    logic on;
    case (pwr)
      PWR_LOW:  on = (slot == 2'd0);
      PWR_MED:  on = ~slot[0];
      PWR_HIGH: on = 1'b1;
      default:  on = 1'b1;
    endcase
    return on;
  endfunction

endpackage

// File: rtl/cook_stage_table.sv
// Program stage register file for the cooking sequencer.
// Ports:
//   clock_i, reset_ni          system clock, async active-low reset
//   we_i, wr_idx_i             write strobe (already gated to IDLE) and index
//   wr_min_i, wr_sec_i         stage time, clamped to 99:59 on write
//   wr_pwr_i, wr_en_i          stage power code and enable
//   search_first_i, from_idx_i finder mode: lowest valid index overall, or
//                              lowest valid index strictly above from_idx_i
//   valid_o                    per-stage valid flags
//   min_o, sec_o, pwr_o        per-stage stored values
//   next_idx_o, found_o        finder result
module cook_stage_table
  import cook_pkg::*;
#(
  parameter int N_STAGES = 4
) (
  input  logic                          clock_i,
  input  logic                          reset_ni,
  input  logic                          we_i,
  input  logic [IDX_W-1:0]              wr_idx_i,
  input  logic [6:0]                    wr_min_i,
  input  logic [6:0]                    wr_sec_i,
  input  logic [1:0]                    wr_pwr_i,
  input  logic                          wr_en_i,
  input  logic                          search_first_i,
  input  logic [IDX_W-1:0]              from_idx_i,
  output logic [N_STAGES-1:0]           valid_o,
  output logic [N_STAGES-1:0][6:0]      min_o,
  output logic [N_STAGES-1:0][6:0]      sec_o,
  output logic [N_STAGES-1:0][1:0]      pwr_o,
  output logic [IDX_W-1:0]              next_idx_o,
  output logic                          found_o
);

  logic [N_STAGES-1:0][6:0] min_q;
  logic [N_STAGES-1:0][6:0] sec_q;
  logic [N_STAGES-1:0][1:0] pwr_q;
  logic [N_STAGES-1:0]      en_q;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      min_q <= '0;
      sec_q <= '0;
      pwr_q <= '0;
      en_q  <= '0;
    end else if (we_i) begin
      min_q[wr_idx_i] <= clamp7(wr_min_i, MAX_MIN);
      sec_q[wr_idx_i] <= clamp7(wr_sec_i, MAX_SEC);
      pwr_q[wr_idx_i] <= wr_pwr_i;
      en_q[wr_idx_i]  <= wr_en_i;
    end
  end

  // A zero-length stage is treated as absent so it is skipped, not run.
  always_comb begin
    valid_o = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      valid_o[i] = en_q[i] && ((min_q[i] != 7'd0) || (sec_q[i] != 7'd0));
    end
  end

  assign min_o = min_q;
  assign sec_o = sec_q;
  assign pwr_o = pwr_q;

  // Scan from the top down so the last hit is the lowest qualifying index.
  always_comb begin
    found_o    = 1'b0;
    next_idx_o = '0;
    for (int i = N_STAGES - 1; i >= 0; i--) begin
      if (valid_o[i] && (search_first_i || (IDX_W'(i) > from_idx_i))) begin
        found_o    = 1'b1;
        next_idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/cook_sequencer.sv
// Multi-stage microwave cooking program controller.
// Steps the countdown timer through the programmed stages and drives the
// magnetron with a duty cycle set by each stage's power level.
// Ports:
//   clock_i, reset_ni      system clock, async active-low reset
//   tick_1hz_i             one-cycle pulse per second
//   start_i, stop_i        edge-detected front-panel pulses
//   porta_i                door level, 1 = open
//   prog_*_i               stage write port (accepted only when idle)
//   tmr_done_i             timer reached 00:00
//   tmr_load_o/min/sec     load pulse and stage time for the timer
//   tmr_start_o, tmr_stop_o one-cycle timer commands
//   tmr_pause_o            timer hold level
//   magnetron_o            heating element enable (registered)
//   stage_idx_o, busy_o, done_beep_o  status
//
// state | meaning
// IDLE  | waiting for start; stage table writable
// LOAD  | timer loaded with the current stage's time
// ARM   | timer start pulse
// RUN   | counting down, magnetron modulated by stage power
// PAUSE | door opened; timer held, magnetron off, waits for start
// DONE  | program finished; beep for BEEP_SEC seconds
module cook_sequencer
  import cook_pkg::*;
#(
  parameter int N_STAGES = 4,
  parameter int BEEP_SEC = 3
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             tick_1hz_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             porta_i,
  input  logic             prog_we_i,
  input  logic [IDX_W-1:0] prog_idx_i,
  input  logic [6:0]       prog_min_i,
  input  logic [6:0]       prog_sec_i,
  input  logic [1:0]       prog_pwr_i,
  input  logic             prog_en_i,
  input  logic             tmr_done_i,
  output logic             tmr_load_o,
  output logic [6:0]       tmr_min_o,
  output logic [6:0]       tmr_sec_o,
  output logic             tmr_start_o,
  output logic             tmr_pause_o,
  output logic             tmr_stop_o,
  output logic             magnetron_o,
  output logic [IDX_W-1:0] stage_idx_o,
  output logic             busy_o,
  output logic             done_beep_o
);

  localparam int BEEP_W = (BEEP_SEC > 1) ? $clog2(BEEP_SEC) : 1;
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_SEC - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   stage_idx_q, stage_idx_d;
  logic [1:0]         slot_q, slot_d;
  logic [BEEP_W-1:0]  beep_q, beep_d;
  logic [6:0]         tmr_min_q, tmr_min_d;
  logic [6:0]         tmr_sec_q, tmr_sec_d;
  logic               tmr_stop_q, tmr_stop_d;
  logic               magnetron_q, magnetron_d;
  logic               load_stage;

  logic [N_STAGES-1:0]      tbl_valid;
  logic [N_STAGES-1:0][6:0] tbl_min;
  logic [N_STAGES-1:0][6:0] tbl_sec;
  logic [N_STAGES-1:0][1:0] tbl_pwr;
  logic [IDX_W-1:0]         next_idx;
  logic                     next_found;

  cook_stage_table #(
    .N_STAGES(N_STAGES)
  ) u_table (
    .clock_i       (clock_i),
    .reset_ni      (reset_ni),
    .we_i          (prog_we_i && (state_q == IDLE)),
    .wr_idx_i      (prog_idx_i),
    .wr_min_i      (prog_min_i),
    .wr_sec_i      (prog_sec_i),
    .wr_pwr_i      (prog_pwr_i),
    .wr_en_i       (prog_en_i),
    .search_first_i(state_q == IDLE),
    .from_idx_i    (stage_idx_q),
    .valid_o       (tbl_valid),
    .min_o         (tbl_min),
    .sec_o         (tbl_sec),
    .pwr_o         (tbl_pwr),
    .next_idx_o    (next_idx),
    .found_o       (next_found)
  );

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      stage_idx_q <= '0;
      slot_q      <= '0;
      beep_q      <= '0;
      tmr_min_q   <= '0;
      tmr_sec_q   <= '0;
      tmr_stop_q  <= 1'b0;
      magnetron_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_idx_q <= stage_idx_d;
      slot_q      <= slot_d;
      beep_q      <= beep_d;
      tmr_min_q   <= tmr_min_d;
      tmr_sec_q   <= tmr_sec_d;
      tmr_stop_q  <= tmr_stop_d;
      magnetron_q <= magnetron_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stage_idx_d = stage_idx_q;
    slot_d      = slot_q;
    beep_d      = beep_q;
    tmr_min_d   = tmr_min_q;
    tmr_sec_d   = tmr_sec_q;
    tmr_stop_d  = 1'b0;
    load_stage  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i && !porta_i && (|tbl_valid) && next_found) begin
          state_d     = LOAD;
          stage_idx_d = next_idx;
          load_stage  = 1'b1;
        end
      end
      LOAD: begin
        slot_d  = 2'd0;
        state_d = ARM;
      end
      ARM: begin
        state_d = RUN;
      end
      RUN: begin
        if (tick_1hz_i) slot_d = slot_q + 2'd1;
        if (stop_i) begin
          tmr_stop_d = 1'b1;
          state_d    = IDLE;
        end else if (porta_i) begin
          state_d = PAUSE;
        end else if (tmr_done_i) begin
          if (next_found) begin
            state_d     = LOAD;
            stage_idx_d = next_idx;
            load_stage  = 1'b1;
          end else begin
            state_d = DONE;
            beep_d  = '0;
          end
        end
      end
      PAUSE: begin
        if (stop_i) begin
          tmr_stop_d = 1'b1;
          state_d    = IDLE;
        end else if (start_i && !porta_i) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (tick_1hz_i) begin
          if (beep_q == BEEP_LAST) state_d = IDLE;
          else                     beep_d  = beep_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Latch the stage time as the FSM enters LOAD so it is stable during the pulse.
    if (load_stage) begin
      tmr_min_d = tbl_min[stage_idx_d];
      tmr_sec_d = tbl_sec[stage_idx_d];
    end
  end

  // Computed from next-state values so the element switches on the same edge
  // the FSM enters or leaves RUN.
  assign magnetron_d = (state_d == RUN) && duty_on(tbl_pwr[stage_idx_d], slot_d);

  assign tmr_load_o  = (state_q == LOAD);
  assign tmr_start_o = (state_q == ARM);
  assign tmr_pause_o = (state_q == PAUSE);
  assign tmr_stop_o  = tmr_stop_q;
  assign tmr_min_o   = tmr_min_q;
  assign tmr_sec_o   = tmr_sec_q;
  assign magnetron_o = magnetron_q;
  assign stage_idx_o = stage_idx_q;
  assign busy_o      = (state_q != IDLE);
  assign done_beep_o = (state_q == DONE);

endmodule

// File: tb/tb_cook_sequencer.sv
module tb_cook_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, start = 1'b0, stop = 1'b0, porta = 1'b0;
  logic       prog_we = 1'b0, prog_en = 1'b0;
  logic [1:0] prog_idx = '0, prog_pwr = '0;
  logic [6:0] prog_min = '0, prog_sec = '0;
  logic       tmr_done = 1'b0;

  logic       tmr_load, tmr_start, tmr_pause, tmr_stop, magnetron, busy, done_beep;
  logic [6:0] tmr_min, tmr_sec;
  logic [1:0] stage_idx;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] idx;
    logic [6:0] mn;
    logic [6:0] sc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  cook_sequencer #(.N_STAGES(4), .BEEP_SEC(3)) dut (
    .clock_i    (clk),
    .reset_ni   (rst_n),
    .tick_1hz_i (tick),
    .start_i    (start),
    .stop_i     (stop),
    .porta_i    (porta),
    .prog_we_i  (prog_we),
    .prog_idx_i (prog_idx),
    .prog_min_i (prog_min),
    .prog_sec_i (prog_sec),
    .prog_pwr_i (prog_pwr),
    .prog_en_i  (prog_en),
    .tmr_done_i (tmr_done),
    .tmr_load_o (tmr_load),
    .tmr_min_o  (tmr_min),
    .tmr_sec_o  (tmr_sec),
    .tmr_start_o(tmr_start),
    .tmr_pause_o(tmr_pause),
    .tmr_stop_o (tmr_stop),
    .magnetron_o(magnetron),
    .stage_idx_o(stage_idx),
    .busy_o     (busy),
    .done_beep_o(done_beep)
  );

  // Scoreboard: every timer load must match the next expected stage.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && tmr_load === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL load_unexpected: got load idx=%0d %0d:%0d, want no load", stage_idx, tmr_min, tmr_sec);
      end else begin
        mon_e = sb.pop_front();
        if (stage_idx !== mon_e.idx || tmr_min !== mon_e.mn || tmr_sec !== mon_e.sc) begin
          n_fail++;
          $display("FAIL load_values: got idx=%0d %0d:%0d, want idx=%0d %0d:%0d",
                   stage_idx, tmr_min, tmr_sec, mon_e.idx, mon_e.mn, mon_e.sc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {tick, start, stop, porta, prog_we, tmr_done} = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic prog(input logic [1:0] idx, input logic [6:0] mn, input logic [6:0] sc,
                      input logic [1:0] pwr, input logic en);
    prog_idx = idx; prog_min = mn; prog_sec = sc; prog_pwr = pwr; prog_en = en;
    prog_we = 1'b1;
    step();
    prog_we = 1'b0;
  endtask

  task automatic run_to_run();
    start = 1'b1; step(); start = 1'b0;
    step();
    step();
  endtask

  task automatic tick_once();
    tick = 1'b1; step(); tick = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({tmr_load, tmr_start, tmr_pause, tmr_stop, magnetron, busy, done_beep, stage_idx, tmr_min, tmr_sec} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b mag=%b idx=%0d min=%0d sec=%0d, want all 0",
               busy, magnetron, stage_idx, tmr_min, tmr_sec);
    end
  endtask

  task automatic test_single_stage();
    do_reset();
    prog(2'd0, 7'd0, 7'd5, 2'd2, 1'b1);
    sb.push_back('{2'd0, 7'd0, 7'd5});
    start = 1'b1; step(); start = 1'b0;
    n_checks++;
    if (tmr_load !== 1'b1) begin n_fail++; $display("FAIL single_load_latency: got tmr_load=%b want 1", tmr_load); end
    step();
    n_checks++;
    if (tmr_start !== 1'b1 || tmr_load !== 1'b0) begin
      n_fail++; $display("FAIL single_start_latency: got tmr_start=%b tmr_load=%b want 1/0", tmr_start, tmr_load);
    end
    step();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (magnetron !== 1'b1) begin n_fail++; $display("FAIL single_mag_full: tick %0d got %b want 1", k, magnetron); end
      tick_once();
    end
    tmr_done = 1'b1; step(); tmr_done = 1'b0;
    n_checks++;
    if (done_beep !== 1'b1 || magnetron !== 1'b0) begin
      n_fail++; $display("FAIL single_done: got beep=%b mag=%b want 1/0", done_beep, magnetron);
    end
    start = 1'b1; step(); start = 1'b0;
    tick_once();
    tick_once();
    n_checks++;
    if (done_beep !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_beep_hold: got beep=%b busy=%b want 1/1", done_beep, busy);
    end
    tick_once();
    n_checks++;
    if (busy !== 1'b0 || done_beep !== 1'b0) begin
      n_fail++; $display("FAIL single_beep_end: got busy=%b beep=%b want 0/0", busy, done_beep);
    end
  endtask

  task automatic test_skip_invalid();
    do_reset();
    prog(2'd0, 7'd0, 7'd10, 2'd2, 1'b0);
    prog(2'd1, 7'd0, 7'd0, 2'd1, 1'b1);
    prog(2'd2, 7'd1, 7'd30, 2'd0, 1'b1);
    sb.push_back('{2'd2, 7'd1, 7'd30});
    run_to_run();
    n_checks++;
    if (stage_idx !== 2'd2) begin n_fail++; $display("FAIL skip_idx: got %0d want 2", stage_idx); end
    n_checks++;
    if (magnetron !== 1'b1) begin n_fail++; $display("FAIL skip_mag_t0: got %b want 1", magnetron); end
    for (int k = 1; k <= 9; k++) begin
      tick_once();
      n_checks++;
      if (magnetron !== ((k % 4) == 0)) begin
        n_fail++; $display("FAIL skip_mag_duty: tick %0d got %b want %b", k, magnetron, (k % 4) == 0);
      end
    end
    stop = 1'b1; step(); stop = 1'b0;
    n_checks++;
    if (tmr_stop !== 1'b1 || busy !== 1'b0 || magnetron !== 1'b0) begin
      n_fail++; $display("FAIL skip_stop: got stop=%b busy=%b mag=%b want 1/0/0", tmr_stop, busy, magnetron);
    end
    step();
    n_checks++;
    if (tmr_stop !== 1'b0) begin n_fail++; $display("FAIL skip_stop_pulse: got %b want 0", tmr_stop); end
  endtask

  task automatic test_door_pause();
    do_reset();
    prog(2'd0, 7'd0, 7'd20, 2'd1, 1'b1);
    sb.push_back('{2'd0, 7'd0, 7'd20});
    run_to_run();
    porta = 1'b1; step();
    n_checks++;
    if (tmr_pause !== 1'b1 || magnetron !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL pause_enter: got pause=%b mag=%b busy=%b want 1/0/1", tmr_pause, magnetron, busy);
    end
    start = 1'b1; step(); start = 1'b0;
    n_checks++;
    if (tmr_pause !== 1'b1) begin n_fail++; $display("FAIL pause_start_door_open: got pause=%b want 1", tmr_pause); end
    porta = 1'b0; step(); step();
    n_checks++;
    if (tmr_pause !== 1'b1 || magnetron !== 1'b0) begin
      n_fail++; $display("FAIL pause_door_closed: got pause=%b mag=%b want 1/0", tmr_pause, magnetron);
    end
    start = 1'b1; step(); start = 1'b0;
    n_checks++;
    if (tmr_pause !== 1'b0 || magnetron !== 1'b1) begin
      n_fail++; $display("FAIL pause_resume: got pause=%b mag=%b want 0/1", tmr_pause, magnetron);
    end
    stop = 1'b1; step(); stop = 1'b0;
    step();
  endtask

  task automatic test_stop_priority();
    do_reset();
    prog(2'd0, 7'd0, 7'd9, 2'd2, 1'b1);
    prog(2'd1, 7'd0, 7'd9, 2'd2, 1'b1);
    sb.push_back('{2'd0, 7'd0, 7'd9});
    run_to_run();
    stop = 1'b1; porta = 1'b1; tmr_done = 1'b1;
    step();
    stop = 1'b0; porta = 1'b0; tmr_done = 1'b0;
    n_checks++;
    if (tmr_stop !== 1'b1 || busy !== 1'b0 || tmr_pause !== 1'b0 || tmr_load !== 1'b0) begin
      n_fail++; $display("FAIL stop_priority: got stop=%b busy=%b pause=%b load=%b want 1/0/0/0",
                         tmr_stop, busy, tmr_pause, tmr_load);
    end
    step();
    n_checks++;
    if (tmr_load !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stop_no_load: got load=%b busy=%b want 0/0", tmr_load, busy);
    end
  endtask

  task automatic test_chain_lockout();
    do_reset();
    prog(2'd0, 7'd0, 7'd3, 2'd2, 1'b1);
    prog(2'd3, 7'd2, 7'd0, 2'd1, 1'b1);
    for (int pass = 0; pass < 2; pass++) begin
      sb.push_back('{2'd0, 7'd0, 7'd3});
      run_to_run();
      if (pass == 0) prog(2'd1, 7'd0, 7'd7, 2'd2, 1'b1);
      sb.push_back('{2'd3, 7'd2, 7'd0});
      tmr_done = 1'b1; step(); tmr_done = 1'b0;
      n_checks++;
      if (tmr_load !== 1'b1 || stage_idx !== 2'd3) begin
        n_fail++; $display("FAIL chain_next: pass %0d got load=%b idx=%0d want 1/3", pass, tmr_load, stage_idx);
      end
      step(); step();
      tmr_done = 1'b1; step(); tmr_done = 1'b0;
      n_checks++;
      if (done_beep !== 1'b1) begin n_fail++; $display("FAIL chain_done: pass %0d got beep=%b want 1", pass, done_beep); end
      if (pass == 0) begin
        tick_once(); tick_once(); tick_once();
      end else begin
        stop = 1'b1; step(); stop = 1'b0;
      end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL chain_idle: pass %0d got busy=%b want 0", pass, busy); end
    end
  endtask

  task automatic test_gating_reset();
    do_reset();
    prog(2'd0, 7'd120, 7'd75, 2'd2, 1'b1);
    porta = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL gate_door_open: got busy=%b want 0", busy); end
    porta = 1'b0;
    sb.push_back('{2'd0, 7'd99, 7'd59});
    run_to_run();
    stop = 1'b1; step(); stop = 1'b0;
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL gate_no_valid: got busy=%b want 0", busy); end
    prog(2'd2, 7'd4, 7'd0, 2'd2, 1'b1);
    sb.push_back('{2'd2, 7'd4, 7'd0});
    run_to_run();
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({tmr_load, tmr_start, tmr_pause, tmr_stop, magnetron, busy, done_beep, stage_idx, tmr_min, tmr_sec} !== '0) begin
      n_fail++; $display("FAIL reset_mid_run: got busy=%b mag=%b idx=%0d min=%0d want all 0",
                         busy, magnetron, stage_idx, tmr_min);
    end
    step();
    rst_n = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_table_cleared: got busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_stage();
    test_skip_invalid();
    test_door_pause();
    test_stop_priority();
    test_chain_lockout();
    test_gating_reset();
    step();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d pending loads want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
